// File: rtl/simon_game_ctrl.sv
// Simon game sequencer: grows a pseudo-random colour sequence in an external memory,
// plays it back on the display outputs and checks the player's presses against it.
module simon_game_ctrl #(
  parameter int         DATA_WIDTH  = 2,
  parameter int         DEPTH       = 16,
  parameter int         SHOW_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  localparam int        AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int        LW          = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  BTN_VALID,
  input  logic [DATA_WIDTH-1:0] BTN_DATA,
  output logic                  MEM_WE,
  output logic [AW-1:0]         MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  SHOW_VALID,
  output logic [DATA_WIDTH-1:0] SHOW_DATA,
  output logic [LW-1:0]         LEVEL,
  output logic                  BUSY,
  output logic                  WIN,
  output logic                  LOSE
);

  localparam int CMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_APPEND, S_PLAY_RD, S_PLAY_ON, S_PLAY_GAP,
    S_WAIT_IN, S_CHECK, S_WIN, S_LOSE
  } state_t;

  state_t                state;
  logic [7:0]            lfsr;
  logic [AW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] btn_lat;
  logic [LW-1:0]         idx_inc;
  logic [DATA_WIDTH-1:0] colour;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  assign idx_inc = LW'(idx) + LW'(1);
  assign colour  = lfsr[DATA_WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      idx        <= '0;
      cnt        <= '0;
      btn_lat    <= '0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      SHOW_VALID <= 1'b0;
      SHOW_DATA  <= '0;
      LEVEL      <= '0;
      BUSY       <= 1'b0;
      WIN        <= 1'b0;
      LOSE       <= 1'b0;
    end else begin
      lfsr     <= lfsr_next(lfsr);
      // Write strobe and address are single-cycle unless a state re-asserts them
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (START) begin
            state     <= S_APPEND;
            LEVEL     <= '0;
            WIN       <= 1'b0;
            LOSE      <= 1'b0;
            BUSY      <= 1'b1;
            MEM_WE    <= 1'b1;
            MEM_WDATA <= colour;
          end
        end
        S_APPEND: begin
          LEVEL <= LEVEL + LW'(1);
          idx   <= '0;
          cnt   <= '0;
          state <= S_PLAY_RD;
        end
        S_PLAY_RD: begin
          if (cnt == CW'(1)) begin
            SHOW_DATA  <= MEM_RDATA;
            SHOW_VALID <= 1'b1;
            cnt        <= '0;
            state      <= S_PLAY_ON;
          end else begin
            cnt      <= cnt + CW'(1);
            MEM_ADDR <= idx;
          end
        end
        S_PLAY_ON: begin
          if (cnt == CW'(SHOW_CYCLES - 1)) begin
            SHOW_VALID <= 1'b0;
            cnt        <= '0;
            state      <= S_PLAY_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PLAY_GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (idx_inc == LEVEL) begin
              idx   <= '0;
              state <= S_WAIT_IN;
            end else begin
              idx      <= idx + AW'(1);
              MEM_ADDR <= idx + AW'(1);
              state    <= S_PLAY_RD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_IN: begin
          if (BTN_VALID) begin
            btn_lat  <= BTN_DATA;
            MEM_ADDR <= idx;
            cnt      <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // First cycle presents the address, second sees the read data
          if (cnt == '0) begin
            cnt      <= CW'(1);
            MEM_ADDR <= idx;
          end else begin
            cnt <= '0;
            if (btn_lat != MEM_RDATA) begin
              LOSE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_LOSE;
            end else if (idx_inc < LEVEL) begin
              idx   <= idx + AW'(1);
              state <= S_WAIT_IN;
            end else if (LEVEL == LW'(DEPTH)) begin
              WIN   <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_WIN;
            end else begin
              MEM_WE    <= 1'b1;
              MEM_ADDR  <= LEVEL[AW-1:0];
              MEM_WDATA <= colour;
              state     <= S_APPEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with a 1-cycle-latency sequence RAM and an LFSR reference.
module tb_simon_game_ctrl;

  localparam int DW = 2;
  localparam int DEPTH = 4;
  localparam int SHOW = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          btn_valid = 1'b0;
  logic [DW-1:0] btn_data = '0;
  logic          mem_we;
  logic [1:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          show_valid;
  logic [DW-1:0] show_data;
  logic [2:0]    level;
  logic          busy, win, lose;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] exp_seq [0:DEPTH-1];
  logic [7:0]    mdl, mdl_prev;

  int            cap_lat;
  logic [DW-1:0] cap_col [0:DEPTH-1];
  int            cap_on  [0:DEPTH-1];
  int            cap_off [0:DEPTH-1];
  bit            cap_to;

  simon_game_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .LFSR_SEED(8'hA5)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .BTN_VALID(btn_valid), .BTN_DATA(btn_data),
    .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
    .SHOW_VALID(show_valid), .SHOW_DATA(show_data), .LEVEL(level),
    .BUSY(busy), .WIN(win), .LOSE(lose)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference LFSR; mdl_prev is the value the DUT saw at the edge that entered APPEND
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl      <= 8'hA5;
      mdl_prev <= 8'hA5;
    end else begin
      mdl_prev <= mdl;
      mdl      <= {mdl[6:0], mdl[7] ^ mdl[5] ^ mdl[4] ^ mdl[3]};
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the second CHECK cycle
  task automatic press(input logic [DW-1:0] c, input logic with_start);
    btn_valid = 1'b1;
    btn_data  = c;
    start     = with_start;
    @(negedge clk);
    btn_valid = 1'b0;
    start     = 1'b0;
    @(negedge clk);
  endtask

  // Called at the APPEND negedge; records n shown colours, returns at the first gap cycle
  task automatic capture_show(input int n, input int btn_at, input int start_at,
                              input logic [DW-1:0] poke_data);
    int cyc = 0;
    int i = 0;
    int run = 0;
    logic prev = 1'b0;
    cap_to = 1'b0;
    cap_lat = -1;
    for (int k = 0; k < DEPTH; k++) begin
      cap_col[k] = '0; cap_on[k] = 0; cap_off[k] = 0;
    end
    while (i < n) begin
      @(negedge clk);
      cyc++;
      btn_valid = (cyc == btn_at);
      btn_data  = poke_data;
      start     = (cyc == start_at);
      if (show_valid) begin
        if (!prev) begin
          cap_col[i] = show_data;
          if (i == 0) cap_lat = cyc;
          else cap_off[i] = run;
          run = 0;
        end
        run++;
      end else begin
        if (prev) begin
          cap_on[i] = run;
          i++;
          run = 0;
        end
        run++;
      end
      prev = show_valid;
      if (cyc > 200) begin
        cap_to = 1'b1;
        break;
      end
    end
    btn_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (10) @(negedge clk);
    checks++;
    if ({mem_we, show_valid, busy, win, lose} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000", {mem_we, show_valid, busy, win, lose});
    end
    checks++;
    if ({mem_addr, mem_wdata, show_data, level} !== 9'b0) begin
      failures++;
      $display("FAIL reset_buses: addr=%0d wdata=%0d show=%0d level=%0d want all 0",
               mem_addr, mem_wdata, show_data, level);
    end
  endtask

  task automatic test_echo_win();
    start_pulse();
    for (int n = 1; n <= DEPTH; n++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 2'(n - 1) || mem_wdata !== mdl_prev[DW-1:0]) begin
        failures++;
        $display("FAIL append_r%0d: we=%b addr=%0d wdata=%0d want we=1 addr=%0d wdata=%0d",
                 n, mem_we, mem_addr, mem_wdata, n - 1, mdl_prev[DW-1:0]);
      end
      exp_seq[n-1] = mdl_prev[DW-1:0];
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL we_one_cycle_r%0d: got %b want 0", n, mem_we);
      end
      capture_show(n, -1, -1, '0);
      checks++;
      if (cap_to || cap_lat !== 2) begin
        failures++;
        $display("FAIL show_latency_r%0d: got %0d timeout=%b want 2 after first read cycle",
                 n, cap_lat, cap_to);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (cap_col[i] !== exp_seq[i] || cap_on[i] !== SHOW) begin
          failures++;
          $display("FAIL show_r%0d_c%0d: colour=%0d on=%0d want colour=%0d on=%0d",
                   n, i, cap_col[i], cap_on[i], exp_seq[i], SHOW);
        end
        if (i > 0) begin
          checks++;
          if (cap_off[i] !== GAP + 2) begin
            failures++;
            $display("FAIL show_off_r%0d_c%0d: got %0d want %0d", n, i, cap_off[i], GAP + 2);
          end
        end
      end
      checks++;
      if (level !== 3'(n)) begin
        failures++;
        $display("FAIL level_r%0d: got %0d want %0d", n, level, n);
      end
      repeat (GAP) @(negedge clk);
      for (int j = 0; j < n; j++) begin
        press(exp_seq[j], 1'b0);
        @(negedge clk);
      end
    end
    checks++;
    if (win !== 1'b1 || busy !== 1'b0 || lose !== 1'b0 || level !== 3'd4) begin
      failures++;
      $display("FAIL win: win=%b busy=%b lose=%b level=%0d want 1 0 0 4", win, busy, lose, level);
    end
  endtask

  task automatic test_lose();
    bit saw_we = 1'b0;
    bit lost_lose = 1'b0;
    start_pulse();
    exp_seq[0] = mdl_prev[DW-1:0];
    checks++;
    if (win !== 1'b0 || mem_addr !== 2'd0 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_win: win=%b addr=%0d we=%b want 0 0 1", win, mem_addr, mem_we);
    end
    capture_show(1, -1, -1, '0);
    repeat (GAP) @(negedge clk);
    press(exp_seq[0], 1'b0);
    @(negedge clk);
    exp_seq[1] = mdl_prev[DW-1:0];
    capture_show(2, -1, -1, '0);
    repeat (GAP) @(negedge clk);
    press(exp_seq[0], 1'b0);
    @(negedge clk);
    press(exp_seq[1] ^ 2'b01, 1'b0);
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lose_early: lose=%b busy=%b want 0 1 in second check cycle", lose, busy);
    end
    @(negedge clk);
    checks++;
    if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || level !== 3'd2) begin
      failures++;
      $display("FAIL lose: lose=%b busy=%b win=%b level=%0d want 1 0 0 2", lose, busy, win, level);
    end
    repeat (10) begin
      @(negedge clk);
      if (mem_we) saw_we = 1'b1;
      if (!lose || level !== 3'd2) lost_lose = 1'b1;
    end
    checks++;
    if (saw_we || lost_lose) begin
      failures++;
      $display("FAIL lose_hold: we_seen=%b flag_dropped=%b want 0 0", saw_we, lost_lose);
    end
  endtask

  task automatic test_restart_from_lose();
    start_pulse();
    checks++;
    if (lose !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== mdl_prev[DW-1:0]) begin
      failures++;
      $display("FAIL restart_lose: lose=%b we=%b addr=%0d wdata=%0d want 0 1 0 %0d",
               lose, mem_we, mem_addr, mem_wdata, mdl_prev[DW-1:0]);
    end
    exp_seq[0] = mdl_prev[DW-1:0];
  endtask

  task automatic test_ignored_inputs();
    // Stray presses carry the wrong colour so an accepted one would end the game
    capture_show(1, 1, 4, ~exp_seq[0]);
    checks++;
    if (cap_to || cap_lat !== 3 || cap_on[0] !== SHOW || cap_col[0] !== exp_seq[0] || level !== 3'd1) begin
      failures++;
      $display("FAIL ignore_r1: lat=%0d on=%0d col=%0d level=%0d want 3 %0d %0d 1",
               cap_lat, cap_on[0], cap_col[0], level, SHOW, exp_seq[0]);
    end
    repeat (GAP) @(negedge clk);
    press(exp_seq[0], 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd1 || lose !== 1'b0) begin
      failures++;
      $display("FAIL ignore_round2: we=%b addr=%0d lose=%b want 1 1 0", mem_we, mem_addr, lose);
    end
    exp_seq[1] = mdl_prev[DW-1:0];
    capture_show(2, 8, 12, ~exp_seq[1]);
    checks++;
    if (cap_to || cap_on[0] !== SHOW || cap_on[1] !== SHOW || cap_off[1] !== GAP + 2 ||
        cap_col[1] !== exp_seq[1] || level !== 3'd2) begin
      failures++;
      $display("FAIL ignore_r2: on=%0d,%0d off=%0d col=%0d level=%0d want %0d,%0d %0d %0d 2",
               cap_on[0], cap_on[1], cap_off[1], cap_col[1], level, SHOW, SHOW, GAP + 2, exp_seq[1]);
    end
    repeat (GAP) @(negedge clk);
    press(exp_seq[0], 1'b1);
    @(negedge clk);
    press(exp_seq[1], 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd2 || busy !== 1'b1 || lose !== 1'b0) begin
      failures++;
      $display("FAIL start_with_press: we=%b addr=%0d busy=%b lose=%b want 1 2 1 0",
               mem_we, mem_addr, busy, lose);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (show_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_show: got %b want 1", show_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (show_valid !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: show=%b busy=%b level=%0d want 0 0 0", show_valid, busy, level);
    end
    @(negedge clk);
    rst = 1'b0;
    start_pulse();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 2'b01) begin
      failures++;
      $display("FAIL seed_colour: we=%b addr=%0d wdata=%0d want 1 0 1", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (level !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_level: level=%0d busy=%b want 1 1", level, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      exp_seq[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_echo_win();
    test_lose();
    test_restart_from_lose();
    test_ignored_inputs();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
